// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: RUN/STOP/CLEAR FSM, 100 Hz divider and cascaded
// centisecond/second/minute/hour counters with a display mux for the FND path.
module stopwatch_ctrl #(
    parameter int TICK_COUNT = 1_000_000,
    parameter int MSEC_MAX   = 100,
    parameter int SEC_MAX    = 60,
    parameter int MIN_MAX    = 60,
    parameter int HOUR_MAX   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_sw_mode,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [6:0] o_bcd_low,
    output logic [5:0] o_bcd_high,
    output logic       o_running
);

    localparam int DIV_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_COUNT - 1);
    localparam logic [6:0] MSEC_LAST = 7'(MSEC_MAX - 1);
    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DIV_W-1:0] div_reg, div_next;
    logic [6:0] msec_reg, msec_next;
    logic [5:0] sec_reg, sec_next;
    logic [5:0] min_reg, min_next;
    logic [4:0] hour_reg, hour_next;

    // Bit 0 is the run button, bit 1 the clear button.
    logic [1:0] btn_in;
    logic [1:0] btn_pulse;
    logic       run_pulse;
    logic       clear_pulse;
    logic       tick;

    assign btn_in = {i_btn_clear, i_btn_run};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic btn_d_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) btn_d_reg <= 1'b0;
                else       btn_d_reg <= btn_in[gi];
            end
            assign btn_pulse[gi] = btn_in[gi] & ~btn_d_reg;
        end
    endgenerate

    assign run_pulse   = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];
    assign tick        = (state_reg == ST_RUN) && (div_reg == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_STOP;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP: begin
                if (clear_pulse)    state_next = ST_CLEAR;
                else if (run_pulse) state_next = ST_RUN;
            end
            ST_RUN:   if (run_pulse) state_next = ST_STOP;
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    always_comb begin
        o_running  = (state_reg == ST_RUN);
        o_bcd_low  = i_sw_mode ? {1'b0, min_reg}  : msec_reg;
        o_bcd_high = i_sw_mode ? {1'b0, hour_reg} : sec_reg;
    end

    // Divider only moves in RUN, so a pause keeps the partial tick.
    always_comb begin
        div_next  = div_reg;
        msec_next = msec_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        if (state_reg == ST_CLEAR) begin
            div_next  = '0;
            msec_next = '0;
            sec_next  = '0;
            min_next  = '0;
            hour_next = '0;
        end else if (state_reg == ST_RUN) begin
            if (!tick) begin
                div_next = div_reg + 1'b1;
            end else begin
                div_next = '0;
                if (msec_reg != MSEC_LAST) begin
                    msec_next = msec_reg + 7'd1;
                end else begin
                    msec_next = '0;
                    if (sec_reg != SEC_LAST) begin
                        sec_next = sec_reg + 6'd1;
                    end else begin
                        sec_next = '0;
                        if (min_reg != MIN_LAST) begin
                            min_next = min_reg + 6'd1;
                        end else begin
                            min_next  = '0;
                            hour_next = (hour_reg != HOUR_LAST) ? hour_reg + 5'd1 : 5'd0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= '0;
            msec_reg <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hour_reg <= '0;
        end else begin
            div_reg  <= div_next;
            msec_reg <= msec_next;
            sec_reg  <= sec_next;
            min_reg  <= min_next;
            hour_reg <= hour_next;
        end
    end

    assign o_msec = msec_reg;
    assign o_sec  = sec_reg;
    assign o_min  = min_reg;
    assign o_hour = hour_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a TICK_COUNT=4 instance for control timing and a
// TICK_COUNT=1 instance with small moduli to walk the full hour wrap quickly.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       btn_run, btn_clear, sw_mode;
    logic [6:0] msec, bcd_low;
    logic [5:0] sec, min, bcd_high;
    logic [4:0] hour;
    logic       running;

    logic       w_btn_run, w_btn_clear, w_sw_mode;
    logic [6:0] w_msec, w_bcd_low;
    logic [5:0] w_sec, w_min, w_bcd_high;
    logic [4:0] w_hour;
    logic       w_running;

    stopwatch_ctrl #(.TICK_COUNT(4)) dut (
        .clk(clk), .reset(reset), .i_btn_run(btn_run), .i_btn_clear(btn_clear),
        .i_sw_mode(sw_mode), .o_msec(msec), .o_sec(sec), .o_min(min), .o_hour(hour),
        .o_bcd_low(bcd_low), .o_bcd_high(bcd_high), .o_running(running)
    );

    // Small moduli: one full day is 4*3*3*2 = 72 ticks.
    stopwatch_ctrl #(.TICK_COUNT(1), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)) dut_w (
        .clk(clk), .reset(reset), .i_btn_run(w_btn_run), .i_btn_clear(w_btn_clear),
        .i_sw_mode(w_sw_mode), .o_msec(w_msec), .o_sec(w_sec), .o_min(w_min), .o_hour(w_hour),
        .o_bcd_low(w_bcd_low), .o_bcd_high(w_bcd_high), .o_running(w_running)
    );

    typedef struct {
        string       step;
        string       fld;
        logic [31:0] exp;
    } exp_t;

    exp_t  sb[$];
    string cur_step;
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    t;

    function automatic logic [31:0] observe(string f);
        case (f)
            "msec":  return 32'(msec);
            "sec":   return 32'(sec);
            "min":   return 32'(min);
            "hour":  return 32'(hour);
            "low":   return 32'(bcd_low);
            "high":  return 32'(bcd_high);
            "run":   return 32'(running);
            "wmsec": return 32'(w_msec);
            "wsec":  return 32'(w_sec);
            "wmin":  return 32'(w_min);
            "whour": return 32'(w_hour);
            "wlow":  return 32'(w_bcd_low);
            "whigh": return 32'(w_bcd_high);
            "wrun":  return 32'(w_running);
            default: return 'x;
        endcase
    endfunction

    task automatic push(string fld, int v);
        exp_t e;
        e.step = cur_step;
        e.fld  = fld;
        e.exp  = 32'(v);
        sb.push_back(e);
    endtask

    task automatic push_main(int ms, int s, int m, int h, int r);
        push("msec", ms); push("sec", s); push("min", m); push("hour", h); push("run", r);
    endtask

    task automatic push_w(int ms, int s, int m, int h, int r);
        push("wmsec", ms); push("wsec", s); push("wmin", m); push("whour", h); push("wrun", r);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.fld);
            n_cmp++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s.%s observed=%0d expected=%0d", e.step, e.fld, o, e.exp);
            end
        end
        $display("step %-14s checks so far %0d", cur_step, n_cmp);
    endtask

    initial begin
        reset = 1'b1;
        btn_run = 1'b0; btn_clear = 1'b0; sw_mode = 1'b0;
        w_btn_run = 1'b0; w_btn_clear = 1'b0; w_sw_mode = 1'b0;

        cur_step = "reset_hold";
        repeat (3) @(negedge clk);
        push_main(0, 0, 0, 0, 0); push("low", 0); push("high", 0);
        push_w(0, 0, 0, 0, 0);
        drain();

        cur_step = "idle20";
        reset = 1'b0;
        repeat (20) @(negedge clk);
        push_main(0, 0, 0, 0, 0); push("low", 0); push("high", 0);
        push_w(0, 0, 0, 0, 0);
        drain();

        // 400 edges at 4 clk/tick = 100 centiseconds.
        cur_step = "run_400";
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push("run", 1); push("msec", 0);
        drain();
        repeat (400) @(negedge clk);
        push_main(0, 1, 0, 0, 1); push("low", 0); push("high", 1);
        drain();
        cur_step = "mode1_early";
        sw_mode = 1'b1;
        #1;
        push("low", 0); push("high", 0);
        drain();
        sw_mode = 1'b0;

        // Stop pulse sampled with div=1 leaves div=2 frozen.
        cur_step = "pause";
        @(negedge clk);
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push_main(0, 1, 0, 0, 0);
        drain();
        repeat (100) @(negedge clk);
        push_main(0, 1, 0, 0, 0);
        drain();

        cur_step = "resume";
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push("run", 1); push("msec", 0);
        drain();
        @(negedge clk);
        push("msec", 0);
        drain();
        @(negedge clk);
        push("msec", 1); push("sec", 1);
        drain();

        cur_step = "clear_in_run";
        btn_clear = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
        repeat (7) @(negedge clk);
        push_main(3, 1, 0, 0, 1);
        drain();

        cur_step = "stop2";
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push_main(3, 1, 0, 0, 0);
        drain();

        cur_step = "clear_stop";
        btn_clear = 1'b1;
        @(negedge clk);
        btn_clear = 1'b0;
        push("run", 0);
        drain();
        @(negedge clk);
        push_main(0, 0, 0, 0, 0); push("low", 0); push("high", 0);
        drain();

        // Divider must restart from 0 after the clear.
        cur_step = "div_cleared";
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push("run", 1); push("msec", 0);
        drain();
        repeat (3) @(negedge clk);
        push("msec", 0);
        drain();
        @(negedge clk);
        push("msec", 1);
        drain();

        cur_step = "stop3";
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        push("run", 0); push("msec", 1);
        drain();

        cur_step = "run_clear_same";
        btn_run = 1'b1;
        btn_clear = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        btn_clear = 1'b0;
        push("run", 0);
        drain();
        @(negedge clk);
        push_main(0, 0, 0, 0, 0);
        drain();
        repeat (10) @(negedge clk);
        push_main(0, 0, 0, 0, 0);
        drain();

        // Full-day walk: expected digits derived from the total tick count t.
        cur_step = "wrap_walk";
        w_btn_run = 1'b1;
        @(negedge clk);
        w_btn_run = 1'b0;
        t = 0;
        push_w(0, 0, 0, 0, 1);
        drain();
        for (int k = 1; k <= 139; k++) begin
            @(negedge clk);
            t++;
            w_btn_run = 1'b0;
            push_w(t % 4, (t / 4) % 3, (t / 12) % 3, (t / 36) % 2, (t < 139) ? 1 : 0);
            drain();
            if (t == 138) w_btn_run = 1'b1;
        end

        cur_step = "wrap_frozen";
        repeat (5) @(negedge clk);
        push_w(3, 1, 2, 1, 0);
        drain();

        cur_step = "w_mode0";
        w_sw_mode = 1'b0;
        #1;
        push("wlow", 3); push("whigh", 1);
        drain();
        cur_step = "w_mode1";
        w_sw_mode = 1'b1;
        #1;
        push("wlow", 2); push("whigh", 1);
        drain();
        w_sw_mode = 1'b0;

        // A run button held for 50 clocks must toggle exactly once.
        cur_step = "hold_run";
        @(negedge clk);
        w_btn_run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i > 0) t++;
            push("wrun", 1); push("wmsec", t % 4); push("wsec", (t / 4) % 3);
            drain();
        end
        w_btn_run = 1'b0;
        repeat (5) @(negedge clk);
        t += 5;
        push_w(t % 4, (t / 4) % 3, (t / 12) % 3, (t / 36) % 2, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
